// File: rtl/conv_dispatcher.sv
// conv_dispatcher: splits a valid-convolution output frame into batches of NMCU lane jobs and collects their dones.
// Optional RUN watchdog enabled by defining DISPATCH_TIMEOUT_EN.
module conv_dispatcher #(
  parameter int NUM_NMCUS = 9,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_INPUT_DIM = 15,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int DIM_W = $clog2(MAX_INPUT_DIM) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [ADDR_WIDTH-1:0]           job_desc_addr,
  input  logic [ADDR_WIDTH-1:0]           job_input_base,
  input  logic [ADDR_WIDTH-1:0]           job_output_base,
  input  logic [DIM_W-1:0]                job_input_width,
  input  logic [DIM_W-1:0]                job_input_height,
  input  logic [DIM_W-1:0]                job_kernel_dim,
  output logic [NUM_NMCUS-1:0]            nmcu_start,
  input  logic [NUM_NMCUS-1:0]            nmcu_done,
  output logic [ADDR_WIDTH-1:0]           nmcu_desc,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] nmcu_input_addr,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] nmcu_output_addr,
  output logic [DIM_W-1:0]                full_input_width,
  output logic [DIM_W-1:0]                full_input_height,
  output logic [DIM_W-1:0]                full_output_width,
  output logic [DIM_W-1:0]                full_output_height,
  output logic                            busy,
  output logic                            job_done,
  output logic                            job_err
);
  localparam int LW = NUM_NMCUS > 1 ? $clog2(NUM_NMCUS) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, ASSIGN, REARM, RUN, FINISH} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] row_in, row_out;
  logic [ADDR_WIDTH-1:0] in_addr [NUM_NMCUS];
  logic [ADDR_WIDTH-1:0] out_addr [NUM_NMCUS];
  logic [DIM_W-1:0] kernel, row, col;
  logic [LW-1:0] lane;
  logic [NUM_NMCUS-1:0] assigned;
  logic more, bad, wrap, last, expired;

  assign job_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bad = job_kernel_dim == '0 || job_input_width == '0 || job_input_height == '0 ||
               job_input_width > DIM_W'(MAX_INPUT_DIM) || job_input_height > DIM_W'(MAX_INPUT_DIM) ||
               job_kernel_dim > job_input_width || job_kernel_dim > job_input_height;
  assign wrap = col == full_output_width - DIM_W'(1);
  assign last = wrap && row == full_output_height - DIM_W'(1);

  for (genvar k = 0; k < NUM_NMCUS; k++) begin : g_lane
    assign nmcu_input_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = in_addr[k];
    assign nmcu_output_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = out_addr[k];
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] run_cnt;
  assign expired = run_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) run_cnt <= (rst || state != RUN) ? '0 : run_cnt + TW'(1);
`else
  // watchdog compiled out: never fires
  assign expired = TIMEOUT_CYCLES < 0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nmcu_start <= '0;
      nmcu_desc <= '0;
      full_input_width <= '0;
      full_input_height <= '0;
      full_output_width <= '0;
      full_output_height <= '0;
      row_in <= '0;
      row_out <= '0;
      kernel <= '0;
      row <= '0;
      col <= '0;
      lane <= '0;
      assigned <= '0;
      more <= 1'b0;
      job_done <= 1'b0;
      job_err <= 1'b0;
      for (int i = 0; i < NUM_NMCUS; i++) begin
        in_addr[i] <= '0;
        out_addr[i] <= '0;
      end
    end else begin
      job_done <= 1'b0;
      job_err <= 1'b0;
      case (state)
        IDLE: if (job_valid) begin
          state <= SETUP;
          nmcu_desc <= job_desc_addr;
          row_in <= job_input_base;
          row_out <= job_output_base;
          full_input_width <= job_input_width;
          full_input_height <= job_input_height;
          kernel <= job_kernel_dim;
          job_err <= bad;
          for (int i = 0; i < NUM_NMCUS; i++) begin
            in_addr[i] <= '0;
            out_addr[i] <= '0;
          end
        end
        SETUP: if (job_err) state <= IDLE;
        else begin
          state <= ASSIGN;
          full_output_width <= full_input_width - kernel + DIM_W'(1);
          full_output_height <= full_input_height - kernel + DIM_W'(1);
          row <= '0;
          col <= '0;
          lane <= '0;
          assigned <= '0;
        end
        ASSIGN: begin
          in_addr[lane] <= row_in + ADDR_WIDTH'(col);
          out_addr[lane] <= row_out + ADDR_WIDTH'(col);
          assigned[lane] <= 1'b1;
          col <= wrap ? '0 : col + DIM_W'(1);
          row <= wrap ? row + DIM_W'(1) : row;
          row_in <= wrap ? row_in + ADDR_WIDTH'(full_input_width) : row_in;
          row_out <= wrap ? row_out + ADDR_WIDTH'(full_output_width) : row_out;
          lane <= lane + LW'(1);
          more <= !last;
          if (last || lane == LW'(NUM_NMCUS - 1)) state <= REARM;
        end
        REARM: if ((nmcu_done & assigned) == '0) begin
          state <= RUN;
          nmcu_start <= assigned;
        end
        RUN: begin
          nmcu_start <= nmcu_start & ~nmcu_done;
          if ((nmcu_start & ~nmcu_done) == '0) begin
            state <= more ? ASSIGN : FINISH;
            job_done <= !more;
            lane <= '0;
            assigned <= '0;
            for (int i = 0; i < NUM_NMCUS; i++) begin
              in_addr[i] <= '0;
              out_addr[i] <= '0;
            end
          end else if (expired) begin
            state <= IDLE;
            nmcu_start <= '0;
            job_err <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_dispatcher.sv
// tb_conv_dispatcher: table-driven and randomized jobs against a position-list model with emulated NMCU lanes.
module tb_conv_dispatcher;
  localparam int N = 9, AW = 16, DW = 5, TO = 64;

  typedef struct {
    logic [DW-1:0] w, h, k;
    logic [AW-1:0] ib, ob;
    bit err;
    int ow, oh, pb, pl;
    logic [AW-1:0] pin, pout;
  } vec_t;

  logic clk = 0, rst, job_valid;
  logic [AW-1:0] job_desc_addr, job_input_base, job_output_base;
  logic [DW-1:0] job_input_width, job_input_height, job_kernel_dim;
  logic [N-1:0] nmcu_done, nmcu_start;
  logic job_ready, busy, job_done, job_err;
  logic [AW-1:0] nmcu_desc;
  logic [N*AW-1:0] nmcu_input_addr, nmcu_output_addr;
  logic [DW-1:0] full_input_width, full_input_height, full_output_width, full_output_height;
  int checks = 0, errors = 0;
  int dly [N];
  int hold;
  vec_t tv [14];

  conv_dispatcher #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_desc_addr(job_desc_addr), .job_input_base(job_input_base), .job_output_base(job_output_base),
    .job_input_width(job_input_width), .job_input_height(job_input_height), .job_kernel_dim(job_kernel_dim),
    .nmcu_start(nmcu_start), .nmcu_done(nmcu_done), .nmcu_desc(nmcu_desc),
    .nmcu_input_addr(nmcu_input_addr), .nmcu_output_addr(nmcu_output_addr),
    .full_input_width(full_input_width), .full_input_height(full_input_height),
    .full_output_width(full_output_width), .full_output_height(full_output_height),
    .busy(busy), .job_done(job_done), .job_err(job_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit bad_job(input int w, input int h, input int k);
    return k == 0 || w == 0 || h == 0 || w > 15 || h > 15 || k > w || k > h;
  endfunction

  task automatic run_job(input vec_t v, input bit exp_to, input int abort_at);
    int total, nb, n1, batch, cyc, pos;
    int cnt [N];
    int hc [N];
    bit fin;
    logic [N-1:0] ps, pd, mask;
    logic [N*AW-1:0] ein, eout;
    logic [AW-1:0] desc;
    total = v.err ? 0 : v.ow * v.oh;
    nb = (total + N - 1) / N;
    n1 = total < N ? total : N;
    desc = AW'($urandom);
    @(negedge clk);
    chk("idle_ready", job_ready, 1);
    job_valid = 1;
    job_desc_addr = desc;
    job_input_base = v.ib;
    job_output_base = v.ob;
    job_input_width = v.w;
    job_input_height = v.h;
    job_kernel_dim = v.k;
    @(negedge clk);
    cyc = 1;
    chk("setup_err", job_err, v.err);
    chk("setup_busy", {busy, job_ready}, 2'b10);
    if (v.err) begin
      job_valid = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("err_no_start", {job_done, job_err, job_ready, nmcu_start}, {1'b0, 1'b0, 1'b1, N'(0)});
      end
      return;
    end
    // held-valid garbage while busy must not disturb the accepted job
    job_desc_addr = ~desc;
    job_input_base = AW'($urandom);
    job_input_width = DW'($urandom);
    job_kernel_dim = DW'($urandom);
    ps = '0;
    pd = '0;
    mask = '0;
    ein = '0;
    eout = '0;
    batch = 0;
    fin = 0;
    nmcu_done = '0;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      hc[k] = 0;
    end
    while (!fin && cyc < 4000) begin
      if (cyc == 2) job_valid = 0;
      if (cyc == abort_at) begin
        rst = 1;
        @(negedge clk);
        chk("rst_midrun", {nmcu_start, busy, job_ready, job_done, job_err}, {N'(0), 4'b0100});
        rst = 0;
        nmcu_done = '0;
        return;
      end
      if (job_done || job_err) fin = 1;
      else begin
        if (nmcu_start != '0 && ps == '0) begin
          if (batch == 0) chk("first_start_cycle", cyc, 3 + n1);
          mask = '0;
          ein = '0;
          eout = '0;
          for (int k = 0; k < N; k++) begin
            pos = batch * N + k;
            if (pos < total) begin
              mask[k] = 1;
              ein[k*AW +: AW] = v.ib + AW'((pos / v.ow) * v.w + pos % v.ow);
              eout[k*AW +: AW] = v.ob + AW'(pos);
            end
          end
          chk("batch_mask", nmcu_start, mask);
          chk("rearm_done_low", pd & mask, 0);
          chk("frame_dims", {full_input_width, full_input_height, full_output_width, full_output_height},
              {v.w, v.h, DW'(v.ow), DW'(v.oh)});
          chk("desc", nmcu_desc, desc);
          if (batch == v.pb) begin
            chk("probe_in", nmcu_input_addr[v.pl*AW +: AW], v.pin);
            chk("probe_out", nmcu_output_addr[v.pl*AW +: AW], v.pout);
          end
          batch++;
        end else if (ps != '0) chk("start_track", nmcu_start, ps & ~pd);
        if (nmcu_start != '0) begin
          chk("in_addr", nmcu_input_addr, ein);
          chk("out_addr", nmcu_output_addr, eout);
        end
        for (int k = 0; k < N; k++) begin
          if (nmcu_start[k]) begin
            hc[k] = hold;
            if (dly[k] >= 0 && cnt[k] >= dly[k]) nmcu_done[k] = 1;
            else cnt[k]++;
          end else begin
            cnt[k] = 0;
            if (batch == nb && !mask[k]) nmcu_done[k] = 1'($urandom_range(0, 1));
            else if (nmcu_done[k] && hc[k] > 0) hc[k]--;
            else nmcu_done[k] = 0;
          end
        end
        ps = nmcu_start;
        pd = nmcu_done;
        @(negedge clk);
        cyc++;
      end
    end
    job_valid = 0;
    if (exp_to) begin
      chk("timeout_cycle", cyc, 3 + n1 + TO);
      chk("timeout_flags", {job_err, job_done, nmcu_start}, {2'b10, N'(0)});
    end else begin
      chk("job_done_seen", {job_done, job_err}, 2'b10);
      chk("batch_count", batch, nb);
      chk("done_start_low", nmcu_start, 0);
    end
    nmcu_done = '0;
    @(negedge clk);
    chk("back_idle", {job_ready, busy, job_done, job_err, nmcu_start}, {4'b1000, N'(0)});
  endtask

  initial begin
    vec_t v;
    rst = 1;
    job_valid = 0;
    job_desc_addr = 0;
    job_input_base = 0;
    job_output_base = 0;
    job_input_width = 0;
    job_input_height = 0;
    job_kernel_dim = 0;
    nmcu_done = 0;
    hold = 0;
    tv[0]  = '{5'd6,  5'd6,  5'd4,  16'h0100, 16'h0200, 1'b0, 3, 3, 0, 4, 16'h0107, 16'h0204};
    tv[1]  = '{5'd6,  5'd6,  5'd4,  16'h0100, 16'h0200, 1'b0, 3, 3, 0, 8, 16'h010E, 16'h0208};
    tv[2]  = '{5'd6,  5'd6,  5'd2,  16'h0100, 16'h0200, 1'b0, 5, 5, 2, 0, 16'h0115, 16'h0212};
    tv[3]  = '{5'd6,  5'd6,  5'd7,  16'h0100, 16'h0200, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[4]  = '{5'd6,  5'd6,  5'd0,  16'h0100, 16'h0200, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[5]  = '{5'd1,  5'd1,  5'd1,  16'h1234, 16'h4321, 1'b0, 1, 1, 0, 0, 16'h1234, 16'h4321};
    tv[6]  = '{5'd15, 5'd15, 5'd15, 16'h0010, 16'h0020, 1'b0, 1, 1, 0, 0, 16'h0010, 16'h0020};
    tv[7]  = '{5'd16, 5'd6,  5'd2,  16'h0000, 16'h0000, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[8]  = '{5'd0,  5'd6,  5'd1,  16'h0000, 16'h0000, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[9]  = '{5'd6,  5'd0,  5'd1,  16'h0000, 16'h0000, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[10] = '{5'd15, 5'd1,  5'd1,  16'hFFF8, 16'hFFFC, 1'b0, 15, 1, 1, 5, 16'h0006, 16'h000A};
    tv[11] = '{5'd3,  5'd7,  5'd3,  16'h0500, 16'h0600, 1'b0, 1, 5, 0, 4, 16'h050C, 16'h0604};
    tv[12] = '{5'd6,  5'd5,  5'd6,  16'h0000, 16'h0000, 1'b1, 0, 0, -1, 0, 16'h0, 16'h0};
    tv[13] = '{5'd9,  5'd4,  5'd3,  16'h0000, 16'h0000, 1'b0, 7, 2, 1, 4, 16'h000F, 16'h000D};
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {job_ready, busy, job_done, job_err, nmcu_start}, {4'b1000, N'(0)});
    chk("reset_addr", nmcu_input_addr | nmcu_output_addr, 0);
    chk("reset_dims", {full_input_width, full_input_height, full_output_width, full_output_height, nmcu_desc}, 0);
    rst = 0;
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < N; k++) dly[k] = (k * 3 + i) % 5;
      hold = i % 3;
      run_job(tv[i], 0, 0);
    end
    // staggered completion with done held high after start falls
    for (int k = 0; k < N; k++) dly[k] = 20;
    dly[2] = 5;
    dly[0] = 12;
    hold = 3;
    v = tv[2];
    v.pb = -1;
    run_job(v, 0, 0);
    // reset while lane 3 never finishes, then a clean job
    for (int k = 0; k < N; k++) dly[k] = 2;
    dly[3] = -1;
    hold = 0;
    run_job(tv[0], 0, 40);
    dly[3] = 1;
    run_job(tv[0], 0, 0);
`ifdef DISPATCH_TIMEOUT_EN
    dly[3] = -1;
    run_job(tv[0], 1, 0);
    dly[3] = 1;
`endif
    for (int j = 0; j < 25; j++) begin
      int w, h, k, m;
      w = $urandom_range(0, 16);
      h = $urandom_range(0, 16);
      m = w < h ? w : h;
      k = $urandom_range(0, m + 1);
      v.w = DW'(w);
      v.h = DW'(h);
      v.k = DW'(k);
      v.ib = AW'($urandom);
      v.ob = AW'($urandom);
      v.err = bad_job(w, h, k);
      v.ow = v.err ? 0 : w - k + 1;
      v.oh = v.err ? 0 : h - k + 1;
      v.pb = -1;
      v.pl = 0;
      v.pin = 0;
      v.pout = 0;
      for (int q = 0; q < N; q++) dly[q] = $urandom_range(0, 6);
      hold = $urandom_range(0, 3);
      run_job(v, 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_dispatcher.md
# conv_dispatcher

Upstream scheduler for the NMCU array. Accepts one convolution job (descriptor pointer, input/output base addresses, input and kernel dimensions), derives the valid-convolution output size, and assigns output positions row-major to up to NUM_NMCUS NMCUs in batches. Drives each NMCU's start, input/output addresses and full-frame dimensions, then collects done. Replaces hand-wired per-NMCU address setup; sits between the host/job source and the nmcu instances sharing mem_interface.

## Interface
- NUM_NMCUS, 9, NMCU lanes driven
- ADDR_WIDTH, 16, address width
- MAX_INPUT_DIM, 15, largest legal input width/height; DIM_W = $clog2(MAX_INPUT_DIM)+1
- TIMEOUT_CYCLES, 4096, RUN watchdog limit (used only with DISPATCH_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_desc_addr  in  ADDR_WIDTH  descriptor pointer
- job_input_base, job_output_base  in  ADDR_WIDTH  frame base addresses
- job_input_width, job_input_height  in  DIM_W  input frame dims
- job_kernel_dim  in  DIM_W  square kernel size
- nmcu_start  out  NUM_NMCUS  per-lane start level
- nmcu_done  in  NUM_NMCUS  per-lane done level
- nmcu_desc  out  ADDR_WIDTH  latched job_desc_addr, broadcast
- nmcu_input_addr, nmcu_output_addr  out  NUM_NMCUS*ADDR_WIDTH  flattened, lane k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- full_input_width, full_input_height, full_output_width, full_output_height  out  DIM_W  broadcast frame dims
- busy  out  1  high outside IDLE
- job_done, job_err  out  1  one-cycle pulses

## Operation
- States: IDLE, SETUP, ASSIGN, REARM, RUN, FINISH.
- IDLE: job_ready=1. On job_valid, latch all job fields, go SETUP.
- SETUP (1 cycle): error if kernel==0, input width/height==0 or >MAX_INPUT_DIM, or kernel>width or kernel>height -> pulse job_err, IDLE, no start ever raised. Else out_w=width-kernel+1, out_h=height-kernel+1, clear row/col counters, go ASSIGN.
- ASSIGN: one lane per cycle, lane 0 upward. Lane gets input_addr=input_base+row*width+col, output_addr=output_base+row*out_w+col, computed incrementally (running row-base registers, no multipliers). Col wraps at out_w, incrementing row. Stops after NUM_NMCUS lanes or after last position (row==out_h-1, col==out_w-1). Unassigned lanes: address 0, start 0. Addresses 16-bit modulo.
- REARM: wait until nmcu_done==0 on every assigned lane, then RUN.
- RUN: nmcu_start high on every assigned lane not yet complete. Lane completes when nmcu_done sampled 1 while its start is 1; its start drops the next cycle and stays low. All assigned lanes complete -> ASSIGN if positions remain, else FINISH.
- FINISH: pulse job_done one cycle, IDLE.
- nmcu_done on unassigned lanes or outside RUN is ignored.

## Timing
- Reset: all outputs 0 except job_ready=1; state IDLE; counters cleared. Reset mid-job drops all starts at that edge; no job_done/job_err.
- Accept cycle T (job_valid && job_ready); SETUP T+1; ASSIGN starts T+2, lasts min(NUM_NMCUS, remaining) cycles; earliest start rise one cycle after REARM entry.
- Addresses and dims stable from ASSIGN write until the lane's start falls.
- Simultaneous done on multiple lanes in one cycle: all complete that cycle.
- job_valid outside IDLE ignored, not queued.

## Configuration
- DISPATCH_TIMEOUT_EN defined: cycle counter cleared on REARM->RUN; if RUN lasts TIMEOUT_CYCLES cycles, all starts drop at next edge, job_err pulses, IDLE, remaining positions discarded.
- Undefined: no counter; RUN waits indefinitely; job_err only from SETUP checks.

## Test plan
- 6x6 input, kernel 4, NUM_NMCUS=9, bases 0x0100/0x0200 -> one batch of 9 lanes; lane 4 input 0x0107 output 0x0204; lane 8 input 0x010E output 0x0208; full_output dims 3; one job_done after all dones.
- 6x6, kernel 2 -> 25 positions, batches 9/9/7; batch 3 lane 0 input 0x0115 output 0x0212; lanes 7,8 start stay 0; job_done once.
- kernel 7 on 6x6 (also kernel 0) -> job_err pulse at T+1, nmcu_start never nonzero, job_ready back high.
- Staggered done (lane 2 at cycle 5, lane 0 at 12, rest at 20) -> each start falls one cycle after its done; next batch waits for slowest lane and done deassertion.
- rst asserted mid-RUN -> nmcu_start=0, busy=0, job_ready=1 next cycle; new job then runs correctly.
- DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=64, lane 3 done held 0 -> job_err after 64 RUN cycles, all starts 0, no job_done.
